// File: rtl/sal_axi_pkg.sv
// rtl/sal_axi_pkg.sv - shared widths and types for the SAL AXI read responder
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

package sal_axi_pkg;

    localparam int ID_W   = `AXI_ID_WIDTH;
    localparam int ADDR_W = `AXI_ADDR_WIDTH;
    localparam int DATA_W = `AXI_DATA_WIDTH;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2
    } axi_burst_t;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        SLVERR = 2'd2
    } axi_resp_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [3:0]      len;
        logic            err;
    } rq_entry_t;

endpackage

// File: rtl/sal_sync_fifo.sv
// rtl/sal_sync_fifo.sv - synchronous FIFO with same-cycle push/pop, push allowed when full if popping
module sal_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign count   = cnt;
    assign head    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
    assign do_push = push & (~full | do_pop);

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sal_axi_read_responder.sv
// rtl/sal_axi_read_responder.sv - AXI AR/R responder with credit-reserved read data buffering
module sal_axi_read_responder
    import sal_axi_pkg::*;
#(
    parameter int CMDQ_DEPTH = 4,
    parameter int DATA_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arvalid,
    output logic              arready,
    input  logic [ID_W-1:0]   arid,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [3:0]        arlen,
    input  logic [1:0]        arburst,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    output logic [3:0]        req_len,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_data,
    output logic              rvalid,
    input  logic              rready,
    output logic [ID_W-1:0]   rid,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rlast
);

    localparam int CW  = $clog2(DATA_DEPTH + 1);
    localparam int RCW = $clog2(CMDQ_DEPTH + 1);

    logic [CW-1:0]     cred;
    logic [CW-1:0]     need;
    logic [3:0]        beat_cnt;
    logic              ar_ok;
    logic              cred_ok;
    logic              ar_hs;
    logic              r_hs;
    logic              take;
    logic              dq_pop;
    logic              rq_pop;

    rq_entry_t         rq_in;
    rq_entry_t         rq_head;
    logic              rq_full;
    logic              rq_empty;
    logic [RCW-1:0]    rq_count;

    logic [DATA_W-1:0] dq_head;
    logic              dq_full;
    logic              dq_empty;
    logic [CW-1:0]     dq_count;

    assign need    = CW'(arlen) + CW'(1);
    assign ar_ok   = (arburst == INCR);
    assign cred_ok = (cred >= need);

    // AR and scheduler request complete together; req_valid must not wait on req_ready.
    always_comb begin
        req_valid = 1'b0;
        arready   = 1'b0;
        if (rst_n) begin
            if (ar_ok) begin
                req_valid = arvalid & ~rq_full & cred_ok;
                arready   = ~rq_full & cred_ok & req_ready;
            end else begin
                arready   = ~rq_full;
            end
        end
    end

    assign req_addr = araddr;
    assign req_len  = arlen;
    assign ar_hs    = arvalid & arready;
    assign take     = ar_hs & ar_ok;

    assign rq_in.id  = arid;
    assign rq_in.len = arlen;
    assign rq_in.err = ~ar_ok;

    sal_sync_fifo #(
        .WIDTH ($bits(rq_entry_t)),
        .DEPTH (CMDQ_DEPTH)
    ) u_rq (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ar_hs),
        .push_data (rq_in),
        .pop       (rq_pop),
        .head      (rq_head),
        .full      (rq_full),
        .empty     (rq_empty),
        .count     (rq_count)
    );

    sal_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DATA_DEPTH)
    ) u_dq (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_valid),
        .push_data (rd_data),
        .pop       (dq_pop),
        .head      (dq_head),
        .full      (dq_full),
        .empty     (dq_empty),
        .count     (dq_count)
    );

    // Error bursts are answered locally and never touch the data FIFO.
    always_comb begin
        rvalid = 1'b0;
        rid    = '0;
        rdata  = '0;
        rresp  = OKAY;
        rlast  = 1'b0;
        if (rst_n && !rq_empty) begin
            rid   = rq_head.id;
            rlast = (beat_cnt == rq_head.len);
            if (rq_head.err) begin
                rvalid = 1'b1;
                rresp  = SLVERR;
            end else begin
                rvalid = ~dq_empty;
                rdata  = dq_head;
            end
        end
    end

    assign r_hs   = rvalid & rready;
    assign dq_pop = r_hs & ~rq_head.err;
    assign rq_pop = r_hs & rlast;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (r_hs) begin
            beat_cnt <= rlast ? 4'd0 : beat_cnt + 4'd1;
        end
    end

    // Credit reserves DQ space at AR accept and returns it as each beat leaves on R.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cred <= CW'(DATA_DEPTH);
        end else begin
            cred <= cred - (take ? need : '0) + CW'(dq_pop);
            assert (!(rd_valid && dq_full));
            assert (!(rd_valid && (({1'b0, cred} + {1'b0, dq_count}) == (CW+1)'(DATA_DEPTH))));
            assert (cred <= CW'(DATA_DEPTH));
            assert (int'(rq_count) <= CMDQ_DEPTH);
        end
    end

endmodule

// File: tb/tb_sal_axi_read_responder.sv
// tb/tb_sal_axi_read_responder.sv - scoreboard bench for sal_axi_read_responder
module tb_sal_axi_read_responder;
    import sal_axi_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              arvalid;
    logic              arready;
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [3:0]        arlen;
    logic [1:0]        arburst;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [3:0]        req_len;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rvalid;
    logic              rready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;

    always #5 clk = ~clk;

    sal_axi_read_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arvalid   (arvalid),
        .arready   (arready),
        .arid      (arid),
        .araddr    (araddr),
        .arlen     (arlen),
        .arburst   (arburst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rvalid    (rvalid),
        .rready    (rready),
        .rid       (rid),
        .rdata     (rdata),
        .rresp     (rresp),
        .rlast     (rlast)
    );

    typedef struct {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } beat_t;

    beat_t             exp_q[$];
    logic [DATA_W-1:0] pend_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int rr_mode = 1;
    int rq_mode = 1;
    bit ret_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // Every beat of an accepted burst is known at accept time; ok data is invented here.
    function automatic void push_exp(input logic [ID_W-1:0] id, input logic [3:0] len, input bit ok);
        beat_t b;
        for (int k = 0; k <= int'(len); k++) begin
            b.id   = id;
            b.last = (k == int'(len));
            if (ok) begin
                b.data = DATA_W'({$urandom, $urandom});
                b.resp = 2'b00;
                pend_q.push_back(b.data);
            end else begin
                b.data = '0;
                b.resp = 2'b10;
            end
            exp_q.push_back(b);
        end
    endfunction

    // Scheduler/DFI side and R sink.
    initial begin
        rready    = 1'b0;
        req_ready = 1'b0;
        rd_valid  = 1'b0;
        rd_data   = '0;
        forever begin
            @(posedge clk);
            #2;
            rready    = (rr_mode == 2) ? ($urandom % 4 != 0) : (rr_mode == 1);
            req_ready = (rq_mode == 2) ? ($urandom % 3 != 0) : (rq_mode == 1);
            rd_valid  = 1'b0;
            if (ret_en && pend_q.size() > 0 && ($urandom % 3 != 0)) begin
                rd_valid = 1'b1;
                rd_data  = pend_q.pop_front();
            end
        end
    end

    // Monitor: R beats against the scoreboard, hold stability, req gating.
    initial begin
        bit    hold;
        beat_t h;
        beat_t e;
        hold = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("hold_rvalid", rvalid, 1);
                    chk("hold_rid", rid, h.id);
                    chk("hold_rdata", rdata, h.data);
                    chk("hold_rresp", rresp, h.resp);
                    chk("hold_rlast", rlast, h.last);
                end
                if (rvalid && rready) begin
                    if (exp_q.size() == 0) begin
                        timeout("r_unexpected_beat");
                    end else begin
                        e = exp_q.pop_front();
                        chk("r_id", rid, e.id);
                        chk("r_data", rdata, e.data);
                        chk("r_resp", rresp, e.resp);
                        chk("r_last", rlast, e.last);
                    end
                end
                if (req_valid) chk("req_valid_gate", (arvalid && arburst == INCR), 1);
                hold   = rvalid && !rready;
                h.id   = rid;
                h.data = rdata;
                h.resp = rresp;
                h.last = rlast;
            end
        end
    end

    task automatic ar_drive(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                            input logic [3:0] len, input logic [1:0] burst);
        @(posedge clk);
        #1;
        arvalid = 1'b1;
        arid    = id;
        araddr  = addr;
        arlen   = len;
        arburst = burst;
    endtask

    task automatic ar_wait(input int max_cyc);
        bit done;
        bit ok;
        done = 1'b0;
        ok   = (arburst == INCR);
        for (int c = 0; c < max_cyc && !done; c++) begin
            @(negedge clk);
            if (arready) begin
                chk("ar_req_valid", req_valid, ok);
                if (ok) begin
                    chk("req_addr", req_addr, araddr);
                    chk("req_len", req_len, arlen);
                end
                push_exp(arid, arlen, ok);
                done = 1'b1;
            end else if (!ok) begin
                chk("err_no_req", req_valid, 0);
            end
        end
        if (!done) timeout("ar_accept");
        @(posedge clk);
        #1;
        arvalid = 1'b0;
    endtask

    task automatic send(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                        input logic [3:0] len, input logic [1:0] burst);
        ar_drive(id, addr, len, burst);
        ar_wait(3000);
    endtask

    task automatic wait_pend();
        int c;
        c = 0;
        while (pend_q.size() != 0 && c < 2000) begin
            @(negedge clk);
            c++;
        end
        if (pend_q.size() != 0) timeout("data_return");
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while ((exp_q.size() != 0 || pend_q.size() != 0) && c < 8000) begin
            @(negedge clk);
            c++;
        end
        if (exp_q.size() != 0) timeout("r_drain");
        repeat (2) @(negedge clk);
        chk("cred_idle", dut.cred, 16);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b;
        rst_n   = 1'b0;
        arvalid = 1'b1;
        arid    = '0;
        araddr  = '0;
        arlen   = '0;
        arburst = INCR;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_arready", arready, 0);
        chk("rst_req_valid", req_valid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rid", rid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_cred", dut.cred, 16);
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        rst_n   = 1'b1;
        ret_en  = 1'b1;

        // Basic INCR burst and back-to-back short bursts.
        send(5, 32'h100, 3, INCR);
        wait_drain();
        send(1, 32'h40, 0, INCR);
        send(2, 32'h80, 1, INCR);
        wait_drain();

        // WRAP answered locally with SLVERR.
        send(7, 32'h180, 1, WRAP);
        wait_drain();

        // Credit stall: len 15 consumes every credit.
        rr_mode = 0;
        send(3, 32'h1000, 15, INCR);
        wait_pend();
        ar_drive(4, 32'h2000, 0, INCR);
        repeat (4) begin
            @(negedge clk);
            chk("stall_arready", arready, 0);
            chk("stall_req_valid", req_valid, 0);
        end
        @(posedge clk);
        #1;
        rr_mode = 1;
        @(negedge clk);
        chk("stall_hs_cycle_arready", arready, 0);
        @(posedge clk);
        #1;
        rr_mode = 0;
        ar_wait(1);
        rr_mode = 1;
        wait_drain();

        // Backpressure and RQ full.
        rr_mode = 0;
        send(9, 32'h200, 3, INCR);
        wait_pend();
        repeat (20) begin
            @(negedge clk);
            chk("bp_rvalid", rvalid, 1);
        end
        send(10, 32'h0, 0, FIXED);
        send(11, 32'h0, 0, INCR);
        send(12, 32'h0, 1, WRAP);
        wait_pend();
        ar_drive(13, 32'h0, 0, WRAP);
        repeat (4) begin
            @(negedge clk);
            chk("rq_full_arready", arready, 0);
        end
        @(posedge clk);
        #1;
        rr_mode = 1;
        ar_wait(50);
        wait_drain();

        // Reset after two of four beats.
        rr_mode = 0;
        send(6, 32'h300, 3, INCR);
        wait_pend();
        @(posedge clk);
        #1;
        rr_mode = 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rr_mode = 0;
        rst_n   = 1'b0;
        ret_en  = 1'b0;
        chk("rst_beats_left", exp_q.size(), 2);
        exp_q.delete();
        pend_q.delete();
        @(negedge clk);
        chk("mid_rst_rvalid", rvalid, 0);
        chk("mid_rst_rlast", rlast, 0);
        chk("mid_rst_rid", rid, 0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        ret_en = 1'b1;
        rr_mode = 1;
        @(negedge clk);
        chk("post_rst_rvalid", rvalid, 0);
        chk("post_rst_cred", dut.cred, 16);
        send(2, 32'h400, 0, INCR);
        wait_drain();

        // Randomized traffic with random backpressure on every side.
        rr_mode = 2;
        rq_mode = 2;
        for (int i = 0; i < 150; i++) begin
            b = int'($urandom % 4);
            send(ID_W'($urandom), ADDR_W'($urandom), 4'($urandom),
                 (b == 0) ? FIXED : (b == 1) ? WRAP : INCR);
            repeat ($urandom % 3) @(posedge clk);
        end
        rr_mode = 1;
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
